// File: rtl/pipe_decode_ctrl.sv
// RV32I decode stage: instruction decode into the ID/EX control register, load-use
// bubbles, EX flush, and multi-cycle MUL sequencing when `MULDIV_EN is defined.
module pipe_decode_ctrl #(
    parameter int REG_AW     = 5,
    parameter int MD_LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [31:0]       id_instr,
    output logic              id_ready,
    input  logic              flush,
    output logic              ex_valid,
    output logic              ex_illegal,
    output logic              ex_reg_write,
    output logic              ex_alu_src1,
    output logic              ex_alu_src2,
    output logic [1:0]        ex_result_src,
    output logic [1:0]        ex_mem_write,
    output logic [2:0]        ex_mem_read,
    output logic [2:0]        ex_br_type,
    output logic [3:0]        ex_alu_control,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_md_busy
);
    localparam int CNT_W = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
    localparam logic [0:0] S_RUN     = 1'b0;
    localparam logic [0:0] S_MD_BUSY = 1'b1;

    typedef struct packed {
        logic              valid;
        logic              illegal;
        logic              reg_write;
        logic              alu_src1;
        logic              alu_src2;
        logic [1:0]        result_src;
        logic [1:0]        mem_write;
        logic [2:0]        mem_read;
        logic [2:0]        br_type;
        logic [3:0]        alu_control;
        logic [REG_AW-1:0] rd;
    } ctrl_t;

    ctrl_t      r_idex_p1;
    logic [0:0] r_state;
    logic [CNT_W-1:0] r_md_cnt;

    ctrl_t      w_dec;
    logic [6:0] w_opcode;
    logic [6:0] w_funct7;
    logic [2:0] w_funct3;
    logic [4:0] w_rd_f;
    logic [4:0] w_rs1_f;
    logic [4:0] w_rs2_f;
    logic       w_rd_used;
    logic       w_rs1_used;
    logic       w_rs2_used;
    logic       w_is_mul;
    logic       w_bad;
    logic       w_hazard;

    assign w_opcode = id_instr[6:0];
    assign w_rd_f   = id_instr[11:7];
    assign w_funct3 = id_instr[14:12];
    assign w_rs1_f  = id_instr[19:15];
    assign w_rs2_f  = id_instr[24:20];
    assign w_funct7 = id_instr[31:25];

    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_op = alt ? 4'b0001 : 4'b0000;
            3'b001:  alu_op = 4'b1000;
            3'b010:  alu_op = 4'b0101;
            3'b011:  alu_op = 4'b1010;
            3'b100:  alu_op = 4'b0110;
            3'b101:  alu_op = alt ? 4'b1001 : 4'b0111;
            3'b110:  alu_op = 4'b0011;
            default: alu_op = 4'b0010;
        endcase
    endfunction

    always_comb begin
        w_dec      = '0;
        w_rd_used  = 1'b0;
        w_rs1_used = 1'b0;
        w_rs2_used = 1'b0;
        w_is_mul   = 1'b0;
        w_bad      = 1'b0;
        case (w_opcode)
            7'b0110011: begin
                w_rd_used = 1'b1; w_rs1_used = 1'b1; w_rs2_used = 1'b1;
                w_dec.reg_write = 1'b1;
                if (w_funct7 == 7'b0000000)
                    w_dec.alu_control = alu_op(w_funct3, 1'b0);
                else if (w_funct7 == 7'b0100000 && (w_funct3 == 3'b000 || w_funct3 == 3'b101))
                    w_dec.alu_control = alu_op(w_funct3, 1'b1);
`ifdef MULDIV_EN
                else if (w_funct7 == 7'b0000001) begin
                    w_dec.alu_control = 4'b1011;
                    w_is_mul          = 1'b1;
                end
`endif
                else
                    w_bad = 1'b1;
            end
            7'b0010011: begin
                w_rd_used = 1'b1; w_rs1_used = 1'b1;
                w_dec.reg_write = 1'b1;
                w_dec.alu_src2  = 1'b1;
                // Only shift-immediates carry a funct7 field; other I-ALU ops use it as immediate.
                if (w_funct3 == 3'b001)
                    w_bad = (w_funct7 != 7'b0000000);
                else if (w_funct3 == 3'b101)
                    w_bad = (w_funct7 != 7'b0000000) && (w_funct7 != 7'b0100000);
                w_dec.alu_control = alu_op(w_funct3, (w_funct3 == 3'b101) && w_funct7[5]);
            end
            7'b0110111: begin
                w_rd_used = 1'b1;
                w_dec.reg_write   = 1'b1;
                w_dec.alu_src2    = 1'b1;
                w_dec.alu_control = 4'b0100;
            end
            7'b0010111: begin
                w_rd_used = 1'b1;
                w_dec.reg_write = 1'b1;
                w_dec.alu_src1  = 1'b1;
                w_dec.alu_src2  = 1'b1;
            end
            7'b1101111: begin
                w_rd_used = 1'b1;
                w_dec.reg_write  = 1'b1;
                w_dec.alu_src1   = 1'b1;
                w_dec.alu_src2   = 1'b1;
                w_dec.result_src = 2'b10;
                w_dec.br_type    = 3'b111;
            end
            7'b1100111: begin
                w_rd_used = 1'b1; w_rs1_used = 1'b1;
                w_dec.reg_write  = 1'b1;
                w_dec.alu_src2   = 1'b1;
                w_dec.result_src = 2'b10;
                w_dec.br_type    = 3'b111;
                w_bad = (w_funct3 != 3'b000);
            end
            7'b1100011: begin
                w_rs1_used = 1'b1; w_rs2_used = 1'b1;
                w_dec.alu_src1 = 1'b1;
                w_dec.alu_src2 = 1'b1;
                case (w_funct3)
                    3'b000:  w_dec.br_type = 3'b001;
                    3'b001:  w_dec.br_type = 3'b010;
                    3'b100:  w_dec.br_type = 3'b101;
                    3'b101:  w_dec.br_type = 3'b110;
                    3'b110:  w_dec.br_type = 3'b011;
                    3'b111:  w_dec.br_type = 3'b100;
                    default: w_bad = 1'b1;
                endcase
            end
            7'b0100011: begin
                w_rs1_used = 1'b1; w_rs2_used = 1'b1;
                w_dec.alu_src2 = 1'b1;
                case (w_funct3)
                    3'b000:  w_dec.mem_write = 2'b01;
                    3'b001:  w_dec.mem_write = 2'b10;
                    3'b010:  w_dec.mem_write = 2'b11;
                    default: w_bad = 1'b1;
                endcase
            end
            7'b0000011: begin
                w_rd_used = 1'b1; w_rs1_used = 1'b1;
                w_dec.reg_write  = 1'b1;
                w_dec.alu_src2   = 1'b1;
                w_dec.result_src = 2'b01;
                case (w_funct3)
                    3'b000:  w_dec.mem_read = 3'b001;
                    3'b001:  w_dec.mem_read = 3'b010;
                    3'b010:  w_dec.mem_read = 3'b000;
                    3'b100:  w_dec.mem_read = 3'b011;
                    3'b101:  w_dec.mem_read = 3'b100;
                    default: w_bad = 1'b1;
                endcase
            end
            default: w_bad = 1'b1;
        endcase
        // Register indices beyond the implemented file (RV32E) make the instruction illegal.
        if ((w_rd_used  && ((w_rd_f  >> REG_AW) != 5'd0)) ||
            (w_rs1_used && ((w_rs1_f >> REG_AW) != 5'd0)) ||
            (w_rs2_used && ((w_rs2_f >> REG_AW) != 5'd0)))
            w_bad = 1'b1;
        w_dec.rd    = w_rd_used ? w_rd_f[REG_AW-1:0] : '0;
        w_dec.valid = 1'b1;
        if (w_bad) begin
            w_dec         = '0;
            w_dec.valid   = 1'b1;
            w_dec.illegal = 1'b1;
            w_rs1_used    = 1'b0;
            w_rs2_used    = 1'b0;
            w_is_mul      = 1'b0;
        end
    end

    assign w_hazard = id_valid && r_idex_p1.valid && (r_idex_p1.result_src == 2'b01) &&
                      (r_idex_p1.rd != '0) &&
                      ((w_rs1_used && (r_idex_p1.rd == w_rs1_f[REG_AW-1:0])) ||
                       (w_rs2_used && (r_idex_p1.rd == w_rs2_f[REG_AW-1:0])));

    assign id_ready = rst_n && !flush && (r_state == S_RUN) && !w_hazard;

    // ID/EX control register (p1)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idex_p1 <= '0;
            r_state   <= S_RUN;
            r_md_cnt  <= '0;
        end else if (flush) begin
            r_idex_p1 <= '0;
            r_state   <= S_RUN;
            r_md_cnt  <= '0;
        end else if (r_state == S_MD_BUSY) begin
            r_md_cnt <= r_md_cnt - CNT_W'(1);
            if (r_md_cnt == CNT_W'(1))
                r_state <= S_RUN;
        end else if (id_valid && id_ready) begin
            r_idex_p1 <= w_dec;
            if (w_is_mul && (MD_LATENCY > 1)) begin
                r_state  <= S_MD_BUSY;
                r_md_cnt <= CNT_W'(MD_LATENCY - 1);
            end
        end else begin
            r_idex_p1 <= '0;
        end
    end

    assign ex_valid       = r_idex_p1.valid;
    assign ex_illegal     = r_idex_p1.illegal;
    assign ex_reg_write   = r_idex_p1.reg_write;
    assign ex_alu_src1    = r_idex_p1.alu_src1;
    assign ex_alu_src2    = r_idex_p1.alu_src2;
    assign ex_result_src  = r_idex_p1.result_src;
    assign ex_mem_write   = r_idex_p1.mem_write;
    assign ex_mem_read    = r_idex_p1.mem_read;
    assign ex_br_type     = r_idex_p1.br_type;
    assign ex_alu_control = r_idex_p1.alu_control;
    assign ex_rd          = r_idex_p1.rd;
    assign ex_md_busy     = (r_state == S_MD_BUSY);

endmodule

// File: tb/tb_pipe_decode_ctrl.sv
// Self-checking bench for pipe_decode_ctrl: directed steps, expected ID/EX bundles
// queued at drive time and compared after the capturing edge.
module tb_pipe_decode_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        flush;

    logic        id_ready, ex_valid, ex_illegal, ex_reg_write, ex_alu_src1, ex_alu_src2, ex_md_busy;
    logic [1:0]  ex_result_src, ex_mem_write;
    logic [2:0]  ex_mem_read, ex_br_type;
    logic [3:0]  ex_alu_control;
    logic [4:0]  ex_rd;

    logic        e_id_ready, e_ex_valid, e_ex_illegal, e_ex_reg_write, e_ex_alu_src1, e_ex_alu_src2, e_ex_md_busy;
    logic [1:0]  e_ex_result_src, e_ex_mem_write;
    logic [2:0]  e_ex_mem_read, e_ex_br_type;
    logic [3:0]  e_ex_alu_control;
    logic [3:0]  e_ex_rd;

    int n_assert = 0;
    int n_fail   = 0;
    logic [24:0] sb[$];

    always #5 clk = ~clk;

    pipe_decode_ctrl #(.REG_AW(5), .MD_LATENCY(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr), .id_ready(id_ready),
        .flush(flush), .ex_valid(ex_valid), .ex_illegal(ex_illegal), .ex_reg_write(ex_reg_write),
        .ex_alu_src1(ex_alu_src1), .ex_alu_src2(ex_alu_src2), .ex_result_src(ex_result_src),
        .ex_mem_write(ex_mem_write), .ex_mem_read(ex_mem_read), .ex_br_type(ex_br_type),
        .ex_alu_control(ex_alu_control), .ex_rd(ex_rd), .ex_md_busy(ex_md_busy)
    );

    pipe_decode_ctrl #(.REG_AW(4), .MD_LATENCY(4)) u_dut_e (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr), .id_ready(e_id_ready),
        .flush(flush), .ex_valid(e_ex_valid), .ex_illegal(e_ex_illegal), .ex_reg_write(e_ex_reg_write),
        .ex_alu_src1(e_ex_alu_src1), .ex_alu_src2(e_ex_alu_src2), .ex_result_src(e_ex_result_src),
        .ex_mem_write(e_ex_mem_write), .ex_mem_read(e_ex_mem_read), .ex_br_type(e_ex_br_type),
        .ex_alu_control(e_ex_alu_control), .ex_rd(e_ex_rd), .ex_md_busy(e_ex_md_busy)
    );

    function automatic logic [24:0] mk(input logic b, input logic v, input logic il, input logic rw,
                                       input logic s1, input logic s2, input logic [1:0] rs,
                                       input logic [1:0] mw, input logic [2:0] mr, input logic [2:0] br,
                                       input logic [3:0] alu, input logic [4:0] rd);
        return {b, v, il, rw, s1, s2, rs, mw, mr, br, alu, rd};
    endfunction

    function automatic logic [24:0] obs();
        return {ex_md_busy, ex_valid, ex_illegal, ex_reg_write, ex_alu_src1, ex_alu_src2,
                ex_result_src, ex_mem_write, ex_mem_read, ex_br_type, ex_alu_control, ex_rd};
    endfunction

    task automatic chk(input string tag, input logic [24:0] o, input logic [24:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    // Drive one cycle, check id_ready before the edge and the ID/EX bundle after it.
    task automatic step(input string tag, input logic v, input logic [31:0] ins, input logic fl,
                        input logic exp_rdy, input logic [24:0] exp_ex);
        logic [24:0] e;
        @(negedge clk);
        id_valid = v; id_instr = ins; flush = fl;
        #1;
        chk({tag, "_rdy"}, {24'd0, id_ready}, {24'd0, exp_rdy});
        sb.push_back(exp_ex);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            e = '1;
            chk({tag, "_sb_empty"}, obs(), e);
        end else begin
            e = sb.pop_front();
            chk(tag, obs(), e);
        end
    endtask

    localparam logic [31:0] ADD_1_2_3  = 32'h003100B3;
    localparam logic [31:0] SUB_1_2_3  = 32'h403100B3;
    localparam logic [31:0] BAD_F7     = 32'h403170B3;
    localparam logic [31:0] LW_5_1     = 32'h0000A283;
    localparam logic [31:0] LW_0_1     = 32'h0000A003;
    localparam logic [31:0] ADD_6_5_2  = 32'h00228333;
    localparam logic [31:0] ADD_6_0_2  = 32'h00200333;
    localparam logic [31:0] ADD_16_2_3 = 32'h00310833;
    localparam logic [31:0] BLTU_1_2   = 32'h0020E063;
    localparam logic [31:0] JALR_1_2   = 32'h000100E7;
    localparam logic [31:0] LUI_3      = 32'h123451B7;
    localparam logic [31:0] SW_2_1     = 32'h0020A223;
    localparam logic [31:0] SRAI_4_1   = 32'h4030D213;
    localparam logic [31:0] MUL_7_1_2  = 32'h022083B3;

    initial begin
        logic [24:0] x_add, x_lw5, x_lw0, x_add6, x_add60, x_ill, x_mul;
        x_add   = mk(0,1,0,1,0,0,2'b00,2'b00,3'b000,3'b000,4'b0000,5'd1);
        x_lw5   = mk(0,1,0,1,0,1,2'b01,2'b00,3'b000,3'b000,4'b0000,5'd5);
        x_lw0   = mk(0,1,0,1,0,1,2'b01,2'b00,3'b000,3'b000,4'b0000,5'd0);
        x_add6  = mk(0,1,0,1,0,0,2'b00,2'b00,3'b000,3'b000,4'b0000,5'd6);
        x_add60 = x_add6;
        x_ill   = mk(0,1,1,0,0,0,2'b00,2'b00,3'b000,3'b000,4'b0000,5'd0);
        x_mul   = mk(1,1,0,1,0,0,2'b00,2'b00,3'b000,3'b000,4'b1011,5'd7);

        rst_n = 1'b0; id_valid = 1'b0; id_instr = 32'h0; flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_ex", obs(), 25'd0);
        chk("reset_rdy", {24'd0, id_ready}, 25'd0);
        rst_n = 1'b1;

        step("add_first",  1'b1, ADD_1_2_3, 1'b0, 1'b1, x_add);
        step("sub",        1'b1, SUB_1_2_3, 1'b0, 1'b1, mk(0,1,0,1,0,0,2'b00,2'b00,3'b000,3'b000,4'b0001,5'd1));
        step("illegal_f7", 1'b1, BAD_F7,    1'b0, 1'b1, x_ill);

        step("lw_x5",      1'b1, LW_5_1,    1'b0, 1'b1, x_lw5);
        step("lu_stall",   1'b1, ADD_6_5_2, 1'b0, 1'b0, 25'd0);
        step("lu_issue",   1'b1, ADD_6_5_2, 1'b0, 1'b1, x_add6);

        step("lw_x0",      1'b1, LW_0_1,    1'b0, 1'b1, x_lw0);
        step("lw_x0_nost", 1'b1, ADD_6_5_2, 1'b0, 1'b1, x_add6);
        step("lw_x0_b",    1'b1, LW_0_1,    1'b0, 1'b1, x_lw0);
        step("rs1_x0",     1'b1, ADD_6_0_2, 1'b0, 1'b1, x_add60);

        step("lw_x5_b",    1'b1, LW_5_1,    1'b0, 1'b1, x_lw5);
        step("flush_stall",1'b1, ADD_6_5_2, 1'b1, 1'b0, 25'd0);
        step("after_flush",1'b1, ADD_6_5_2, 1'b0, 1'b1, x_add6);

        step("rv32e_rd16", 1'b1, ADD_16_2_3, 1'b0, 1'b1, mk(0,1,0,1,0,0,2'b00,2'b00,3'b000,3'b000,4'b0000,5'd16));
        chk("rv32e_illegal", {23'd0, e_ex_valid, e_ex_illegal}, 25'd3);
        chk("rv32e_regwr",   {24'd0, e_ex_reg_write}, 25'd0);

        step("bltu",       1'b1, BLTU_1_2,  1'b0, 1'b1, mk(0,1,0,0,1,1,2'b00,2'b00,3'b000,3'b011,4'b0000,5'd0));
        step("jalr",       1'b1, JALR_1_2,  1'b0, 1'b1, mk(0,1,0,1,0,1,2'b10,2'b00,3'b000,3'b111,4'b0000,5'd1));
        step("lui",        1'b1, LUI_3,     1'b0, 1'b1, mk(0,1,0,1,0,1,2'b00,2'b00,3'b000,3'b000,4'b0100,5'd3));
        step("sw",         1'b1, SW_2_1,    1'b0, 1'b1, mk(0,1,0,0,0,1,2'b00,2'b11,3'b000,3'b000,4'b0000,5'd0));
        step("srai",       1'b1, SRAI_4_1,  1'b0, 1'b1, mk(0,1,0,1,0,1,2'b00,2'b00,3'b000,3'b000,4'b1001,5'd4));
        step("no_valid",   1'b0, ADD_1_2_3, 1'b0, 1'b1, 25'd0);

`ifdef MULDIV_EN
        step("mul_k",      1'b1, MUL_7_1_2, 1'b0, 1'b1, x_mul);
        step("mul_k1",     1'b1, ADD_1_2_3, 1'b0, 1'b0, x_mul);
        step("mul_k2",     1'b1, ADD_1_2_3, 1'b0, 1'b0, x_mul);
        step("mul_k3",     1'b1, ADD_1_2_3, 1'b0, 1'b0, {1'b0, x_mul[23:0]});
        step("mul_next",   1'b1, ADD_1_2_3, 1'b0, 1'b1, x_add);
        step("mul2_k",     1'b1, MUL_7_1_2, 1'b0, 1'b1, x_mul);
        step("mul2_k1",    1'b1, ADD_1_2_3, 1'b0, 1'b0, x_mul);
        step("mul2_flush", 1'b1, ADD_1_2_3, 1'b1, 1'b0, 25'd0);
        step("mul2_after", 1'b1, ADD_1_2_3, 1'b0, 1'b1, x_add);
`else
        step("mul_illegal",1'b1, MUL_7_1_2, 1'b0, 1'b1, x_ill);
        step("mul_nobusy", 1'b1, ADD_1_2_3, 1'b0, 1'b1, x_add);
`endif

        // Asynchronous reset in the middle of a cycle with a live instruction in ID/EX.
        step("pre_reset",  1'b1, LW_5_1,    1'b0, 1'b1, x_lw5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ex", obs(), 25'd0);
        chk("async_rst_rdy", {24'd0, id_ready}, 25'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_reset", 1'b1, ADD_1_2_3, 1'b0, 1'b1, x_add);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
